// File: rtl/calc_pkg.sv
// Shared calculator definitions: operand/result widths, op codes, sequencer states
// and the registered result payload.
package calc_pkg;

   localparam int unsigned NUM_W  = 17;
   localparam int unsigned RES_W  = 20;
   localparam int unsigned PROD_W = 2 * NUM_W;
   localparam int unsigned CNT_W  = $clog2(NUM_W);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CALC   = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   typedef struct packed {
      logic [RES_W-1:0] result;
      logic [NUM_W-1:0] remainder;
      logic             negative;
      logic             ovf;
      logic             div0;
   } calc_res_t;

endpackage

// File: rtl/calc_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, emit the quotient bit.
module calc_div_step
   import calc_pkg::*;
(
   input  logic [NUM_W-1:0] rem_in,
   input  logic             dividend_bit,
   input  logic [NUM_W-1:0] divisor,
   output logic [NUM_W-1:0] rem_out,
   output logic             q_bit
);

   logic [NUM_W:0] trial;
   logic [NUM_W:0] diff;

   // The restored remainder is always below the divisor, so NUM_W bits suffice.
   always_comb begin
      trial   = {rem_in, dividend_bit};
      diff    = trial - {1'b0, divisor};
      q_bit   = (trial >= {1'b0, divisor});
      rem_out = q_bit ? NUM_W'(diff) : NUM_W'(trial);
   end

endmodule

// File: rtl/calc_alu_sequencer.sv
// Multi-cycle arithmetic sequencer: single-cycle add/sub, 17-cycle shift-add
// multiply and restoring divide, with held result and a one-cycle done pulse.
module calc_alu_sequencer
   import calc_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op_code,
   input  logic [NUM_W-1:0] num1,
   input  logic [NUM_W-1:0] num2,
   output logic             busy,
   output logic             done,
   output logic [RES_W-1:0] result,
   output logic [NUM_W-1:0] remainder,
   output logic             negative,
   output logic             ovf,
   output logic             div0
);

   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [1:0]        op_q, op_d;
   logic [NUM_W-1:0]  a_q, a_d, b_q, b_d;
   logic [PROD_W-1:0] acc, acc_d, mcand, mcand_d;
   logic [NUM_W-1:0]  shreg, shreg_d;
   logic [NUM_W-1:0]  rem_q, rem_d, quo, quo_d;
   calc_res_t         res_q, res_d;

   logic [PROD_W-1:0] prod_c;
   logic [NUM_W-1:0]  quo_nx_c;
   logic [NUM_W-1:0]  step_rem_c;
   logic              step_q_c;
   logic              last_c;

   calc_div_step u_div_step (
      .rem_in       (rem_q),
      .dividend_bit (shreg[NUM_W-1]),
      .divisor      (b_q),
      .rem_out      (step_rem_c),
      .q_bit        (step_q_c)
   );

   // Status decoded straight from the state register.
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_FINISH);
   assign result    = res_q.result;
   assign remainder = res_q.remainder;
   assign negative  = res_q.negative;
   assign ovf       = res_q.ovf;
   assign div0      = res_q.div0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         acc   <= '0;
         mcand <= '0;
         shreg <= '0;
         rem_q <= '0;
         quo   <= '0;
         res_q <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         op_q  <= op_d;
         a_q   <= a_d;
         b_q   <= b_d;
         acc   <= acc_d;
         mcand <= mcand_d;
         shreg <= shreg_d;
         rem_q <= rem_d;
         quo   <= quo_d;
         res_q <= res_d;
      end
   end

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc;
      mcand_d  = mcand;
      shreg_d  = shreg;
      rem_d    = rem_q;
      quo_d    = quo;
      res_d    = res_q;

      prod_c   = acc + (shreg[0] ? mcand : '0);
      quo_nx_c = {quo[NUM_W-2:0], step_q_c};
      last_c   = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                 ((op_q == OP_DIV) && (b_q == '0)) ||
                 (cnt == CNT_W'(NUM_W - 1));

      case (state)
         S_IDLE: begin
            if (start) begin
               state_d = S_CALC;
               cnt_d   = '0;
               op_d    = op_code;
               a_d     = num1;
               b_d     = num2;
               acc_d   = '0;
               mcand_d = PROD_W'(num1);
               // Multiplier shifts out LSB-first, dividend MSB-first.
               shreg_d = (op_code == OP_DIV) ? num1 : num2;
               rem_d   = '0;
               quo_d   = '0;
            end
         end

         S_CALC: begin
            cnt_d = cnt + CNT_W'(1);
            if (op_q == OP_MUL) begin
               acc_d   = prod_c;
               mcand_d = mcand << 1;
               shreg_d = shreg >> 1;
            end else if (op_q == OP_DIV) begin
               rem_d   = step_rem_c;
               quo_d   = quo_nx_c;
               shreg_d = shreg << 1;
            end

            if (last_c) begin
               state_d = S_FINISH;
               res_d   = '0;
               case (op_q)
                  OP_ADD: res_d.result = RES_W'(a_q) + RES_W'(b_q);
                  OP_SUB: begin
                     if (a_q >= b_q) begin
                        res_d.result = RES_W'(a_q - b_q);
                     end else begin
                        res_d.result   = RES_W'(b_q - a_q);
                        res_d.negative = 1'b1;
                     end
                  end
                  OP_MUL: begin
                     res_d.ovf    = |prod_c[PROD_W-1:RES_W];
                     res_d.result = res_d.ovf ? '1 : prod_c[RES_W-1:0];
                  end
                  OP_DIV: begin
                     if (b_q == '0) begin
                        res_d.div0 = 1'b1;
                     end else begin
                        res_d.result    = RES_W'(quo_nx_c);
                        res_d.remainder = step_rem_c;
                     end
                  end
                  default: ;
               endcase
            end
         end

         S_FINISH: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

endmodule
